decode_stage: RTL and testbench

Pipelined, parametrised RV32I(+M) decode stage that sits between fetch and execute. It accepts instructions over a valid/ready handshake and decodes them into a registered control bundle. Decode stays combinational in front of the output register. It adds a one-entry skid buffer, illegal-instruction detection, optional M-extension decode, load-use bubble insertion and flush. Branch outcome is not resolved here; branch type is forwarded to execute.

---
 rtl/decode_stage.sv | 209 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I(+M) decode into a registered control bundle with skid buffer, load-use bubble and flush
module decode_stage #(
  parameter bit ENABLE_M      = 1'b1,
  parameter bit ENABLE_HAZARD = 1'b1,
  parameter int PC_W          = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_inst_i,
  input  logic [PC_W-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [PC_W-1:0] out_pc_o,
  output logic [4:0]      out_alu_sel_o,
  output logic            out_a_sel_o,
  output logic            out_b_sel_o,
  output logic [1:0]      out_wb_sel_o,
  output logic            out_reg_we_o,
  output logic            out_dmem_we_o,
  output logic [2:0]      out_dmem_mode_o,
  output logic [2:0]      out_igen_sel_o,
  output logic            out_branch_o,
  output logic            out_jump_o,
  output logic            out_br_un_o,
  output logic [2:0]      out_br_funct_o,
  output logic [4:0]      out_ra_o,
  output logic [4:0]      out_rb_o,
  output logic [4:0]      out_rd_o,
  output logic            out_illegal_o
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_COPY_B = 5'd18;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      alu_sel;
    logic            a_sel;
    logic            b_sel;
    logic [1:0]      wb_sel;
    logic            reg_we;
    logic            dmem_we;
    logic [2:0]      dmem_mode;
    logic [2:0]      igen_sel;
    logic            branch;
    logic            jump;
    logic            br_un;
    logic [2:0]      br_funct;
    logic [4:0]      ra;
    logic [4:0]      rb;
    logic [4:0]      rd;
    logic            illegal;
  } ctrl_t;

  state_t     state_q, state_d;
  ctrl_t      out_q, out_d, skid_q, skid_d, dec;
  logic       skid_tag_q, skid_tag_d, bub_q, bub_d, ill, dec_tag, acc, hs;
  logic [4:0] last_ld_q, last_ld_d, dec_ld, base_alu;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;

  assign opc = in_inst_i[6:0];
  assign rd  = in_inst_i[11:7];
  assign f3  = in_inst_i[14:12];
  assign rs1 = in_inst_i[19:15];
  assign rs2 = in_inst_i[24:20];
  assign f7  = in_inst_i[31:25];
  assign base_alu = f3 == 3'd0 ? 5'd0 : f3 == 3'd6 ? 5'd8 : f3 == 3'd7 ? 5'd9 : {2'b00, f3} + 5'd1;

  // Decode the offered word; illegal encodings collapse to a bundle carrying only the illegal flag and PC
  always_comb begin
    dec = '0;
    ill = 1'b0;
    case (opc)
      OPC_OP: begin
        dec.reg_we = 1'b1; dec.wb_sel = 2'd1; dec.ra = rs1; dec.rb = rs2; dec.rd = rd;
        if (f7 == 7'b0000000) dec.alu_sel = base_alu;
        else if (f7 == 7'b0100000 && f3 == 3'b000) dec.alu_sel = ALU_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101) dec.alu_sel = ALU_SRA;
        else if (ENABLE_M && f7 == 7'b0000001) dec.alu_sel = 5'd10 + {2'b00, f3};
        else ill = 1'b1;
      end
      OPC_IMM: begin
        dec.reg_we = 1'b1; dec.wb_sel = 2'd1; dec.b_sel = 1'b1; dec.ra = rs1; dec.rd = rd;
        dec.alu_sel = (f3 == 3'b101 && in_inst_i[30]) ? ALU_SRA : base_alu;
        ill = (f3 == 3'b001 && f7 != 7'b0000000) || (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
      end
      OPC_LOAD: begin
        dec.reg_we = 1'b1; dec.b_sel = 1'b1; dec.ra = rs1; dec.rd = rd;
        dec.dmem_mode = f3[2] ? f3 - 3'd1 : f3;
        ill = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      OPC_STORE: begin
        dec.dmem_we = 1'b1; dec.dmem_mode = f3; dec.b_sel = 1'b1; dec.igen_sel = 3'd1; dec.ra = rs1; dec.rb = rs2;
        ill = f3 > 3'b010;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1; dec.br_un = f3[1]; dec.br_funct = f3; dec.igen_sel = 3'd2;
        dec.a_sel = 1'b1; dec.b_sel = 1'b1; dec.ra = rs1; dec.rb = rs2;
        ill = f3[2:1] == 2'b01;
      end
      OPC_JAL: begin
        dec.reg_we = 1'b1; dec.wb_sel = 2'd2; dec.jump = 1'b1; dec.igen_sel = 3'd3;
        dec.a_sel = 1'b1; dec.b_sel = 1'b1; dec.rd = rd;
      end
      OPC_JALR: begin
        dec.reg_we = 1'b1; dec.wb_sel = 2'd2; dec.jump = 1'b1; dec.b_sel = 1'b1; dec.ra = rs1; dec.rd = rd;
        ill = f3 != 3'b000;
      end
      OPC_LUI: begin
        dec.reg_we = 1'b1; dec.wb_sel = 2'd1; dec.alu_sel = ALU_COPY_B; dec.b_sel = 1'b1; dec.igen_sel = 3'd4; dec.rd = rd;
      end
      OPC_AUIPC: begin
        dec.reg_we = 1'b1; dec.wb_sel = 2'd1; dec.a_sel = 1'b1; dec.b_sel = 1'b1; dec.igen_sel = 3'd4; dec.rd = rd;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec = '0;
      dec.illegal = 1'b1;
    end
    dec.pc = in_pc_i;
  end

  assign dec_tag     = ENABLE_HAZARD && last_ld_q != 5'd0 && (dec.ra == last_ld_q || dec.rb == last_ld_q);
  assign dec_ld      = (opc == OPC_LOAD && !dec.illegal) ? dec.rd : 5'd0;
  assign in_ready_o  = state_q != TWO;
  assign out_valid_o = state_q != EMPTY && !bub_q;
  assign acc         = in_valid_i && in_ready_o && !flush_i;
  assign hs          = out_valid_o && out_ready_i;

  // Occupancy FSM: route accepted bundles into OUT or SKID and arm the one-cycle load-use bubble
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    skid_d     = skid_q;
    skid_tag_d = skid_tag_q;
    bub_d      = 1'b0;
    last_ld_d  = acc ? dec_ld : last_ld_q;
    case (state_q)
      EMPTY: if (acc) begin
        state_d = ONE; out_d = dec; bub_d = dec_tag;
      end
      ONE: if (acc && hs) begin
        out_d = dec; bub_d = dec_tag;
      end else if (acc) begin
        state_d = TWO; skid_d = dec; skid_tag_d = dec_tag;
      end else if (hs) begin
        state_d = EMPTY;
      end
      default: if (hs) begin
        state_d = ONE; out_d = skid_q; bub_d = skid_tag_q;
      end
    endcase
    if (flush_i) begin
      state_d = EMPTY; bub_d = 1'b0; last_ld_d = 5'd0;
    end
  end

  // State and storage registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      skid_tag_q <= 1'b0;
      bub_q      <= 1'b0;
      last_ld_q  <= 5'd0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      skid_tag_q <= skid_tag_d;
      bub_q      <= bub_d;
      last_ld_q  <= last_ld_d;
    end
  end

  assign out_pc_o        = out_q.pc;
  assign out_alu_sel_o   = out_q.alu_sel;
  assign out_a_sel_o     = out_q.a_sel;
  assign out_b_sel_o     = out_q.b_sel;
  assign out_wb_sel_o    = out_q.wb_sel;
  assign out_reg_we_o    = out_q.reg_we;
  assign out_dmem_we_o   = out_q.dmem_we;
  assign out_dmem_mode_o = out_q.dmem_mode;
  assign out_igen_sel_o  = out_q.igen_sel;
  assign out_branch_o    = out_q.branch;
  assign out_jump_o      = out_q.jump;
  assign out_br_un_o     = out_q.br_un;
  assign out_br_funct_o  = out_q.br_funct;
  assign out_ra_o        = out_q.ra;
  assign out_rb_o        = out_q.rb;
  assign out_rd_o        = out_q.rd;
  assign out_illegal_o   = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a behavioural model
module tb_decode_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  alu;
    logic        a, b;
    logic [1:0]  wb;
    logic        we, dwe;
    logic [2:0]  dm, ig;
    logic        br, jp, bu;
    logic [2:0]  bf;
    logic [4:0]  ra, rb, rd;
    logic        ill;
  } exp_t;
  typedef struct packed {
    exp_t        e;
    logic        tag;
    logic [31:0] id;
  } ent_t;

  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0, in_pc = '0;
  logic in_ready, out_valid, a_sel, b_sel, reg_we, dmem_we, branch, jump, br_un, illegal;
  logic [31:0] out_pc;
  logic [4:0] alu_sel, ra, rb, rd;
  logic [1:0] wb_sel;
  logic [2:0] dmem_mode, igen_sel, br_funct;
  logic n_in_ready, n_out_valid, n_a_sel, n_b_sel, n_reg_we, n_dmem_we, n_branch, n_jump, n_br_un, n_illegal;
  logic [31:0] n_out_pc;
  logic [4:0] n_alu_sel, n_ra, n_rb, n_rd;
  logic [1:0] n_wb_sel;
  logic [2:0] n_dmem_mode, n_igen_sel, n_br_funct;
  int total = 0, bad = 0;
  logic [4:0] base_tab [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
  logic [2:0] mode_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd3, 3'd4, 3'd0, 3'd0};

  always #5 clk = ~clk;

  decode_stage #(.ENABLE_M(1'b1), .ENABLE_HAZARD(1'b1), .PC_W(32)) dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_inst_i(in_inst), .in_pc_i(in_pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_pc_o(out_pc), .out_alu_sel_o(alu_sel), .out_a_sel_o(a_sel), .out_b_sel_o(b_sel),
    .out_wb_sel_o(wb_sel), .out_reg_we_o(reg_we), .out_dmem_we_o(dmem_we), .out_dmem_mode_o(dmem_mode),
    .out_igen_sel_o(igen_sel), .out_branch_o(branch), .out_jump_o(jump), .out_br_un_o(br_un),
    .out_br_funct_o(br_funct), .out_ra_o(ra), .out_rb_o(rb), .out_rd_o(rd), .out_illegal_o(illegal));

  decode_stage #(.ENABLE_M(1'b0), .ENABLE_HAZARD(1'b0), .PC_W(32)) dut_nom (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(n_in_ready),
    .in_inst_i(in_inst), .in_pc_i(in_pc), .out_valid_o(n_out_valid), .out_ready_i(out_ready),
    .out_pc_o(n_out_pc), .out_alu_sel_o(n_alu_sel), .out_a_sel_o(n_a_sel), .out_b_sel_o(n_b_sel),
    .out_wb_sel_o(n_wb_sel), .out_reg_we_o(n_reg_we), .out_dmem_we_o(n_dmem_we), .out_dmem_mode_o(n_dmem_mode),
    .out_igen_sel_o(n_igen_sel), .out_branch_o(n_branch), .out_jump_o(n_jump), .out_br_un_o(n_br_un),
    .out_br_funct_o(n_br_funct), .out_ra_o(n_ra), .out_rb_o(n_rb), .out_rd_o(n_rd), .out_illegal_o(n_illegal));

  function automatic exp_t act();
    return {out_pc, alu_sel, a_sel, b_sel, wb_sel, reg_we, dmem_we, dmem_mode, igen_sel,
            branch, jump, br_un, br_funct, ra, rb, rd, illegal};
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] pc, input bit m);
    exp_t e;
    bit ok;
    logic [2:0] f3;
    logic [6:0] f7;
    e = '0; ok = 1'b1; f3 = i[14:12]; f7 = i[31:25];
    case (i[6:0])
      7'h33: begin
        e.we = 1; e.wb = 1; e.ra = i[19:15]; e.rb = i[24:20]; e.rd = i[11:7];
        if (f7 == 7'h00) e.alu = base_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 5'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 5'd7;
        else if (f7 == 7'h01 && m) e.alu = 5'(10 + int'(f3));
        else ok = 0;
      end
      7'h13: begin
        e.we = 1; e.wb = 1; e.b = 1; e.ra = i[19:15]; e.rd = i[11:7];
        if (f3 == 3'd1) begin ok = f7 == 7'h00; e.alu = 5'd2; end
        else if (f3 == 3'd5) begin ok = f7 == 7'h00 || f7 == 7'h20; e.alu = f7 == 7'h20 ? 5'd7 : 5'd6; end
        else e.alu = base_tab[f3];
      end
      7'h03: begin
        ok = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        e.we = 1; e.b = 1; e.ra = i[19:15]; e.rd = i[11:7]; e.dm = mode_tab[f3];
      end
      7'h23: begin ok = f3 <= 3'd2; e.dwe = 1; e.dm = f3; e.b = 1; e.ig = 1; e.ra = i[19:15]; e.rb = i[24:20]; end
      7'h63: begin
        ok = f3 != 3'd2 && f3 != 3'd3;
        e.br = 1; e.bu = (f3 == 3'd6 || f3 == 3'd7); e.bf = f3; e.ig = 2; e.a = 1; e.b = 1;
        e.ra = i[19:15]; e.rb = i[24:20];
      end
      7'h6F: begin e.we = 1; e.wb = 2; e.jp = 1; e.ig = 3; e.a = 1; e.b = 1; e.rd = i[11:7]; end
      7'h67: begin ok = f3 == 3'd0; e.we = 1; e.wb = 2; e.jp = 1; e.b = 1; e.ra = i[19:15]; e.rd = i[11:7]; end
      7'h37: begin e.we = 1; e.wb = 1; e.alu = 5'd18; e.b = 1; e.ig = 4; e.rd = i[11:7]; end
      7'h17: begin e.we = 1; e.wb = 1; e.a = 1; e.b = 1; e.ig = 4; e.rd = i[11:7]; end
      default: ok = 0;
    endcase
    if (!ok) begin e = '0; e.ill = 1; end
    e.pc = pc;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0] r1, r2, d;
    logic [2:0] f;
    logic [6:0] f7;
    logic [31:0] x, y;
    r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
    f = 3'($urandom_range(0, 7)); x = $urandom;
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = x[31:25];
    endcase
    case ($urandom_range(0, 9))
      0: y = {f7, r2, r1, f, d, 7'h33};
      1: y = {f7, x[24:20], r1, f, d, 7'h13};
      2: y = {x[31:20], r1, f, d, 7'h03};
      3: y = {x[31:25], r2, r1, f, x[11:7], 7'h23};
      4: y = {x[31:25], r2, r1, f, x[11:7], 7'h63};
      5: y = {x[31:12], d, 7'h6F};
      6: y = {x[31:20], r1, x[0] ? f : 3'b000, d, 7'h67};
      7: y = {x[31:12], d, 7'h37};
      8: y = {x[31:12], d, 7'h17};
      default: y = x;
    endcase
    return y;
  endfunction

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc, input logic rdy, input logic fl);
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = rdy; flush = fl;
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    total++; if (act() !== '0) begin bad++; $display("FAIL reset_fields: got %h want 0", act()); end
  endtask

  task automatic test_stream();
    drive(1, 32'h002081B3, 32'h100, 1, 0);
    total++; if ({out_valid, alu_sel, reg_we, wb_sel, out_pc} !== {1'b1, 5'd0, 1'b1, 2'd1, 32'h100})
      begin bad++; $display("FAIL stream_add: got %b/%0d/%b/%0d/%h want 1/0/1/1/100", out_valid, alu_sel, reg_we, wb_sel, out_pc); end
    drive(1, 32'h402081B3, 32'h104, 1, 0);
    total++; if ({out_valid, alu_sel, reg_we, out_pc} !== {1'b1, 5'd1, 1'b1, 32'h104})
      begin bad++; $display("FAIL stream_sub: got %b/%0d/%b/%h want 1/1/1/104", out_valid, alu_sel, reg_we, out_pc); end
    drive(0, 0, 0, 1, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1, 32'h00100093, 32'h200, 0, 0);
    total++; if ({in_ready, out_valid, out_pc} !== {2'b11, 32'h200})
      begin bad++; $display("FAIL bp_first: got %b/%b/%h want 1/1/200", in_ready, out_valid, out_pc); end
    drive(1, 32'h00200113, 32'h204, 0, 0);
    total++; if ({in_ready, out_pc} !== {1'b0, 32'h200})
      begin bad++; $display("FAIL bp_full: got %b/%h want 0/200", in_ready, out_pc); end
    drive(1, 32'h00300193, 32'h208, 0, 0);
    total++; if ({in_ready, out_valid, out_pc, rd} !== {2'b01, 32'h200, 5'd1})
      begin bad++; $display("FAIL bp_hold: got %b/%b/%h/%0d want 0/1/200/1", in_ready, out_valid, out_pc, rd); end
    drive(1, 32'h00300193, 32'h208, 1, 0);
    total++; if ({in_ready, out_valid, out_pc, rd} !== {2'b11, 32'h204, 5'd2})
      begin bad++; $display("FAIL bp_second: got %b/%b/%h/%0d want 1/1/204/2", in_ready, out_valid, out_pc, rd); end
    drive(1, 32'h00300193, 32'h208, 1, 0);
    total++; if ({out_valid, out_pc, rd} !== {1'b1, 32'h208, 5'd3})
      begin bad++; $display("FAIL bp_third: got %b/%h/%0d want 1/208/3", out_valid, out_pc, rd); end
    drive(0, 0, 0, 1, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_hazard();
    drive(1, 32'h0000A283, 32'h300, 1, 0);
    total++; if ({out_valid, out_pc, wb_sel, dmem_mode, rd} !== {1'b1, 32'h300, 2'd0, 3'd2, 5'd5})
      begin bad++; $display("FAIL hz_load: got %b/%h/%0d/%0d/%0d want 1/300/0/2/5", out_valid, out_pc, wb_sel, dmem_mode, rd); end
    drive(1, 32'h00028333, 32'h304, 1, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hz_bubble: got %b want 0", out_valid); end
    drive(0, 0, 0, 1, 0);
    total++; if ({out_valid, out_pc, ra} !== {1'b1, 32'h304, 5'd5})
      begin bad++; $display("FAIL hz_after: got %b/%h/%0d want 1/304/5", out_valid, out_pc, ra); end
    drive(1, 32'h0000A003, 32'h308, 1, 0);
    total++; if ({out_valid, out_pc} !== {1'b1, 32'h308}) begin bad++; $display("FAIL hz_x0_load: got %b/%h want 1/308", out_valid, out_pc); end
    drive(1, 32'h00028333, 32'h30C, 1, 0);
    total++; if ({out_valid, out_pc} !== {1'b1, 32'h30C}) begin bad++; $display("FAIL hz_x0_nobubble: got %b/%h want 1/30c", out_valid, out_pc); end
    drive(0, 0, 0, 1, 0);
  endtask

  task automatic test_m_ext();
    drive(0, 0, 0, 1, 1);
    drive(1, 32'h02208133, 32'h400, 1, 0);
    total++; if ({out_valid, alu_sel, illegal, reg_we} !== {1'b1, 5'd10, 1'b0, 1'b1})
      begin bad++; $display("FAIL m_mul: got %b/%0d/%b/%b want 1/10/0/1", out_valid, alu_sel, illegal, reg_we); end
    total++; if ({n_out_valid, n_illegal, n_reg_we, n_alu_sel, n_rd} !== {1'b1, 1'b1, 1'b0, 5'd0, 5'd0})
      begin bad++; $display("FAIL m_disabled: got %b/%b/%b/%0d/%0d want 1/1/0/0/0", n_out_valid, n_illegal, n_reg_we, n_alu_sel, n_rd); end
    drive(1, 32'h0000007F, 32'h404, 1, 0);
    total++; if ({out_valid, illegal, reg_we, dmem_we} !== 4'b1100) begin bad++; $display("FAIL ill_opcode: got %b%b%b%b want 1100", out_valid, illegal, reg_we, dmem_we); end
    drive(1, 32'h0000B283, 32'h408, 1, 0);
    total++; if ({out_valid, illegal, reg_we, rd, out_pc} !== {3'b110, 5'd0, 32'h408})
      begin bad++; $display("FAIL ill_load: got %b/%b/%b/%0d/%h want 1/1/0/0/408", out_valid, illegal, reg_we, rd, out_pc); end
    drive(1, 32'h00002063, 32'h40C, 1, 0);
    total++; if ({out_valid, illegal, branch, ig_zero()} !== 4'b1101) begin bad++; $display("FAIL ill_branch: got %b%b%b igen %0d want 110 igen 0", out_valid, illegal, branch, igen_sel); end
    drive(0, 0, 0, 1, 0);
  endtask

  function automatic logic ig_zero();
    return igen_sel == 3'd0 && br_funct == 3'd0;
  endfunction

  task automatic test_misc_decode();
    drive(1, 32'h4020D093, 32'h500, 1, 0);
    total++; if ({out_valid, alu_sel, b_sel, ra, rb} !== {1'b1, 5'd7, 1'b1, 5'd1, 5'd0})
      begin bad++; $display("FAIL srai: got %b/%0d/%b/%0d/%0d want 1/7/1/1/0", out_valid, alu_sel, b_sel, ra, rb); end
    drive(1, 32'h0020E063, 32'h504, 1, 0);
    total++; if ({branch, br_un, br_funct, igen_sel, reg_we, jump} !== {2'b11, 3'd6, 3'd2, 2'b00})
      begin bad++; $display("FAIL bltu: got %b/%b/%0d/%0d/%b/%b want 1/1/6/2/0/0", branch, br_un, br_funct, igen_sel, reg_we, jump); end
    drive(1, 32'h12345297, 32'h508, 1, 0);
    total++; if ({a_sel, b_sel, wb_sel, igen_sel, rd, reg_we} !== {2'b11, 2'd1, 3'd4, 5'd5, 1'b1})
      begin bad++; $display("FAIL auipc: got %b/%b/%0d/%0d/%0d/%b want 1/1/1/4/5/1", a_sel, b_sel, wb_sel, igen_sel, rd, reg_we); end
    drive(0, 0, 0, 1, 0);
  endtask

  task automatic test_flush();
    drive(1, 32'h00100093, 32'h600, 0, 0);
    drive(1, 32'h00200113, 32'h604, 0, 0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_two: got %b want 0", in_ready); end
    drive(1, 32'h00300193, 32'h608, 0, 1);
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL fl_empty: got %b%b want 01", out_valid, in_ready); end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_dropped: got %b pc %h want 0", out_valid, out_pc); end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 32'h00100093, 32'h700, 0, 0);
    drive(1, 32'h00200113, 32'h704, 0, 0);
    in_valid = 0;
    #2 reset = 1;
    #1;
    total++; if ({out_valid, in_ready, out_pc} !== {2'b01, 32'h0})
      begin bad++; $display("FAIL areset: got %b/%b/%h want 0/1/0", out_valid, in_ratio(), out_pc); end
    #1 reset = 0;
    @(negedge clk);
    drive(0, 0, 0, 1, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_after: got %b want 0", out_valid); end
  endtask

  function automatic logic in_ratio();
    return in_ready;
  endfunction

  task automatic test_random();
    ent_t q[$];
    ent_t n;
    exp_t e;
    logic [4:0] ld;
    logic bub, v, r, fl, acc, hs, eir, eov;
    logic [31:0] nid, old, inst, pc;
    drive(0, 0, 0, 1, 1);
    ld = 0; bub = 0; nid = 0;
    for (int c = 0; c < 1500; c++) begin
      eir = q.size() < 2;
      eov = q.size() != 0 && !bub;
      total++; if (in_ready !== eir) begin bad++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, in_ready, eir); end
      total++; if (out_valid !== eov) begin bad++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, out_valid, eov); end
      if (eov) begin
        total++; if (act() !== q[0].e) begin bad++; $display("FAIL rnd_bundle c=%0d: got %h want %h", c, act(), q[0].e); end
      end
      v = $urandom_range(0, 9) < 7;
      r = $urandom_range(0, 9) < 6;
      fl = $urandom_range(0, 49) == 0;
      inst = rand_inst();
      pc = $urandom & 32'hFFFF_FFFC;
      acc = v && eir && !fl;
      hs = eov && r;
      if (fl) begin
        q.delete(); ld = 0; bub = 0;
      end else begin
        old = q.size() != 0 ? q[0].id : 32'hFFFF_FFFF;
        if (hs) void'(q.pop_front());
        if (acc) begin
          e = ref_dec(inst, pc, 1'b1);
          n.e = e; n.tag = ld != 0 && (e.ra == ld || e.rb == ld); n.id = nid; nid++;
          q.push_back(n);
          ld = (inst[6:0] == 7'h03 && !e.ill) ? e.rd : 5'd0;
        end
        bub = q.size() != 0 && q[0].id != old && q[0].tag;
      end
      drive(v, inst, pc, r, fl);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_back_to_back();
    test_hazard();
    test_m_ext();
    test_misc_decode();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
